// File: rtl/base_arsched_pkg.sv
// Shared helpers for the credit scheduler: counter and index widths derived
// from lane/credit parameters.
package base_arsched_pkg;

    function automatic int cnt_width(input int n);
        return $clog2(n + 1);
    endfunction

    // A single-lane arbiter still needs a 1-bit pointer to keep types legal.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/base_rr_pick.sv
// Combinational rotate-priority picker: one-hot grant to the first set request
// at or after ptr_i, wrapping around; zero when nothing is requested.
module base_rr_pick
    import base_arsched_pkg::*;
#(
    parameter int width = 1,
    localparam int PW = idx_width(width)
) (
    input  logic [0:width-1] req_i,
    input  logic [PW-1:0]    ptr_i,
    output logic [0:width-1] gnt_o
);

    logic found;
    int   idx;

    always_comb begin
        gnt_o = '0;
        found = 1'b0;
        idx   = 0;
        for (int i = 0; i < width; i++) begin
            idx = int'(ptr_i) + i;
            if (idx >= width) begin
                idx = idx - width;
            end
            if (!found && req_i[idx]) begin
                gnt_o[idx] = 1'b1;
                found      = 1'b1;
            end
        end
    end

endmodule

// File: rtl/base_arfilter_sched.sv
// Credit-based round-robin scheduler that drives the per-lane en qualifier of
// an accept/repeat filter bank; at most one lane is enabled per cycle.
module base_arfilter_sched
    import base_arsched_pkg::*;
#(
    parameter int width   = 1,
    parameter int credits = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [0:width-1] i_v,
    input  logic [0:width-1] o_r,
    output logic [0:width-1] en,
    input  logic [0:width-1] crd_rtn,
    output logic             idle,
    output logic             err
);

    localparam int cwidth = cnt_width(credits);
    localparam int PW     = idx_width(width);
    localparam logic [cwidth-1:0] FULL = cwidth'(credits);

    logic [cwidth-1:0] cnt_q [width];
    logic [cwidth-1:0] cnt_d [width];
    logic [0:width-1]  elig;
    logic [0:width-1]  gnt;
    logic [0:width-1]  ovf;
    logic [0:width-1]  full_d;
    logic [PW-1:0]     ptr_q;
    logic [PW-1:0]     ptr_d;
    logic              err_q;
    logic              idle_q;

    // Eligibility looks only at registered credit, so crd_rtn never reaches en.
    generate
        for (genvar gi = 0; gi < width; gi++) begin : g_lane
            assign elig[gi] = i_v[gi] & o_r[gi] & (cnt_q[gi] != '0);

            assign ovf[gi] = crd_rtn[gi] & ~en[gi] & (cnt_q[gi] == FULL);

            assign cnt_d[gi] = (en[gi] & ~crd_rtn[gi])                         ? cnt_q[gi] - 1'b1 :
                               (crd_rtn[gi] & ~en[gi] & (cnt_q[gi] != FULL))   ? cnt_q[gi] + 1'b1 :
                                                                                 cnt_q[gi];

            assign full_d[gi] = (cnt_d[gi] == FULL);

            always_ff @(posedge clk) begin
                if (reset) begin
                    cnt_q[gi] <= FULL;
                end else begin
                    cnt_q[gi] <= cnt_d[gi];
                end
            end
        end
    endgenerate

    base_rr_pick #(
        .width (width)
    ) u_pick (
        .req_i (elig),
        .ptr_i (ptr_q),
        .gnt_o (gnt)
    );

    assign en = reset ? '0 : gnt;

    // Pointer moves just past the granted lane so it drops to lowest priority.
    always_comb begin
        ptr_d = ptr_q;
        for (int k = 0; k < width; k++) begin
            if (en[k]) begin
                ptr_d = (k == width - 1) ? '0 : PW'(k + 1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ptr_q  <= '0;
            err_q  <= 1'b0;
            idle_q <= 1'b1;
        end else begin
            ptr_q  <= ptr_d;
            err_q  <= err_q | (|ovf);
            idle_q <= &full_d;
        end
    end

    assign idle = idle_q;
    assign err  = err_q;

endmodule

// File: doc/base_arfilter_sched.md
Name: base_arfilter_sched

Overview:
Credit-based round-robin scheduler that drives the per-lane en qualifier of a width-lane accept/repeat filter bank. Each cycle it enables at most one lane: a lane that has input valid, downstream ready and a nonzero credit count. Each accepted transfer consumes one credit; downstream returns credits with per-lane pulses. It sits beside the filter bank and shares one downstream resource fairly among width requesters while bounding outstanding transfers per lane.

Parameters:
width, 1, number of lanes/requesters
credits, 4, per-lane credit count loaded at reset; also the per-lane maximum (>=1)
cwidth, $clog2(credits+1), localparam: credit counter width, not overridable

Ports:
clk  input  1  clock, all state on rising edge
reset  input  1  synchronous, active-high reset
i_v  input  [0:width-1]  per-lane input valid, same signal the filter sees
o_r  input  [0:width-1]  per-lane downstream ready, same signal the filter sees
en  output  [0:width-1]  per-lane filter qualifier; one-hot or zero
crd_rtn  input  [0:width-1]  per-lane credit-return pulse, +1 credit per cycle asserted
idle  output  1  registered; 1 when every lane holds exactly credits credits
err  output  1  registered, sticky; set on credit return to a full lane

Behaviour:
- State: cnt[k] (cwidth bits) per lane; rr pointer ptr (index 0..width-1); err; idle.
- Reset (clk edge with reset=1): cnt[k]<=credits, ptr<=0, err<=0, idle<=1. While reset=1, en is forced to 0 combinationally.
- elig[k] = i_v[k] & o_r[k] & (cnt[k]!=0).
- en is combinational, zero latency: one-hot grant to the first elig lane searching ptr, ptr+1, ... width-1, 0, ... ptr-1. en=0 when no lane is eligible. Filter i_r = o_r & en, so a grant is exactly one accepted transfer.
- Pointer: on a grant to lane g, ptr<=(g+1) mod width. With no grant, ptr holds. width=1 means ptr is constant 0.
- Counter update per lane, same edge:
  - grant only: cnt-1.
  - crd_rtn only, cnt<credits: cnt+1.
  - grant and crd_rtn together: unchanged.
  - crd_rtn only, cnt==credits: saturate (unchanged) and set err<=1.
- Grant is impossible when cnt==0, so no underflow.
- err stays 1 until reset.
- idle <= (all next-state cnt == credits); it reflects state one cycle after the update.
- A lane with i_v=1 but o_r=0 or zero credit is skipped without consuming its turn. Starvation-free: an eligible lane is granted within width cycles.
- Reset mid-operation: all outstanding credits are forgotten (counters refilled). Returns arriving after reset are treated as normal returns; returns to a full lane flag err.
- No combinational path from crd_rtn to en. Paths exist from i_v and o_r to en.

Decomposition:
- Shared package base_arsched_pkg: none required beyond a function for the clog2-based counter width, if the team package lacks one.
- One natural sub-module, base_rr_pick(width): combinational rotate-priority one-hot picker, taking a request vector and ptr, returning a one-hot grant. It is reusable by other arbiters.
- The credit counters are inline per-lane generate logic.

Test Plan:
- Reset and idle: width=4, credits=2, hold reset 3 cycles with all i_v/o_r=1 -> en=0000 during reset; after release idle=1, err=0, first en=1000.
- Round-robin fairness: width=4, credits=4, i_v=o_r=1111, no returns -> en sequence 1000, 0100, 0010, 0001, 1000, 0100, 0010, 0001; then 0000 once all cnt=0; idle=0.
- Credit exhaustion and return: width=2, credits=1, only lane 0 valid -> one grant, then en=00; pulse crd_rtn=10 -> next cycle en=10 again; idle returns to 1 one cycle after the final return.
- Simultaneous grant and return: width=1, credits=2, after one grant (cnt=1), assert i_v=o_r=1 and crd_rtn=1 together for 5 cycles -> en=1 every cycle, cnt stays 1, err=0.
- Skip on not-ready: width=3, i_v=111, o_r=101, ptr=1 -> grant lane 2 (en=001), then lane 0 (en=100); lane 1 is never granted while o_r[1]=0.
- Overflow error: width=2, credits=3, idle, pulse crd_rtn=01 -> err=1 next cycle and cnt[1] stays 3; err holds until reset is asserted, then clears.
